// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit single-cycle core.
// Holds default widths, the program-counter FSM state type and the halt opcode
// shared between the decoder and the fetch sequencer.
package core_pkg;

  localparam int unsigned PcWDefault    = 10;
  localparam int unsigned LutAwDefault  = 5;
  localparam int unsigned CntWDefault   = 16;

  localparam logic [7:0]  OpHalt        = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } pc_state_t;

endpackage

// File: rtl/branch_lut.sv
// Branch-target jump table.
// Ports:
//   clk_i, rst_ni     - clock, asynchronous active-low reset (clears every entry)
//   we_i/waddr_i/wdata_i - synchronous write port, accepted at all times
//   raddr_i/rdata_o   - combinational read of the registered array
// A write and read of the same index in one cycle returns the old entry.
module branch_lut #(
  parameter int unsigned LUT_AW = 5,
  parameter int unsigned PC_W   = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [LUT_AW-1:0] waddr_i,
  input  logic [PC_W-1:0]   wdata_i,
  input  logic [LUT_AW-1:0] raddr_i,
  output logic [PC_W-1:0]   rdata_o
);

  localparam int unsigned Entries = 2 ** LUT_AW;

  logic [PC_W-1:0] mem_q [Entries];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Entries; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pc_unit.sv
// Program-counter and fetch-sequencing stage.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, start_addr   - host request to begin a run and its initial PC
//   stall               - hold PC and counter this cycle
//   branch, taken, target_idx - conditional branch via jump table
//   halt                - current instruction is halt; ends the run
//   lut_we/lut_waddr/lut_wdata - jump-table write port
//   pc_o                - current instruction address
//   fetch_en            - instruction at pc_o executes this cycle
//   busy, done          - run status decoded from state
//   instr_cnt           - saturating count of retired instructions
module pc_unit
  import core_pkg::*;
#(
  parameter int unsigned PC_W   = PcWDefault,
  parameter int unsigned LUT_AW = LutAwDefault,
  parameter int unsigned CNT_W  = CntWDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  input  logic              stall,
  input  logic              branch,
  input  logic              taken,
  input  logic [LUT_AW-1:0] target_idx,
  input  logic              halt,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc_o,
  output logic              fetch_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  instr_cnt
);

  pc_state_t        state_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [PC_W-1:0]  lut_rdata;

  branch_lut #(
    .LUT_AW (LUT_AW),
    .PC_W   (PC_W)
  ) u_branch_lut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (lut_we),
    .waddr_i (lut_waddr),
    .wdata_i (lut_wdata),
    .raddr_i (target_idx),
    .rdata_o (lut_rdata)
  );

  // Saturate rather than wrap so an overflowed count stays recognisable.
  always_comb begin
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_q <= LOAD;
        end
        LOAD: begin
          pc_q    <= start_addr;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          // Stall outranks everything, including halt and branches.
          if (!stall) begin
            cnt_q <= cnt_inc;
            if (halt) begin
              state_q <= DONE;
            end else if (branch && taken) begin
              pc_q <= lut_rdata;
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (start) state_q <= LOAD;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pc_o      = pc_q;
  assign instr_cnt = cnt_q;
  assign fetch_en  = (state_q == RUN) && !stall;
  assign busy      = (state_q == LOAD) || (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stall, branch, taken, halt, lut_we;
  logic [9:0] start_addr, lut_wdata;
  logic [4:0] target_idx, lut_waddr;

  logic [9:0]  pc_o, pc_s;
  logic        fetch_en, busy, done, fe_s, busy_s, done_s;
  logic [15:0] instr_cnt;
  logic [3:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  // Reference model: run-phase flags, PC, counters and jump table.
  bit         m_loading, m_running, m_done;
  int         m_pc, m_cnt, m_cnt4;
  logic [9:0] m_lut [32];

  always #5 clk = ~clk;

  pc_unit #(.PC_W(10), .LUT_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .stall(stall),
    .branch(branch), .taken(taken), .target_idx(target_idx), .halt(halt),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc_o(pc_o), .fetch_en(fetch_en), .busy(busy), .done(done), .instr_cnt(instr_cnt)
  );

  pc_unit #(.PC_W(10), .LUT_AW(5), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .stall(stall),
    .branch(branch), .taken(taken), .target_idx(target_idx), .halt(halt),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc_o(pc_s), .fetch_en(fe_s), .busy(busy_s), .done(done_s), .instr_cnt(cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_loading = 0; m_running = 0; m_done = 0;
    m_pc = 0; m_cnt = 0; m_cnt4 = 0;
    for (int i = 0; i < 32; i++) m_lut[i] = '0;
  endtask

  task automatic check_all();
    chk("pc", 32'(pc_o), 32'(m_pc));
    chk("cnt", 32'(instr_cnt), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_loading || m_running));
    chk("done", 32'(done), 32'(m_done));
    chk("fetch_en", 32'(fetch_en), 32'(m_running && !stall));
    chk("pc_small", 32'(pc_s), 32'(m_pc));
    chk("cnt_small", 32'(cnt_s), 32'(m_cnt4));
    chk("busy_small", 32'(busy_s), 32'(m_loading || m_running));
    chk("done_small", 32'(done_s), 32'(m_done));
    chk("fe_small", 32'(fe_s), 32'(m_running && !stall));
  endtask

  // Called at a falling edge with inputs set: check, advance model on the rising edge.
  task automatic tick();
    logic [9:0] tgt;
    #1 check_all();
    @(posedge clk);
    tgt = m_lut[target_idx];
    if (m_loading) begin
      m_pc = int'(start_addr); m_cnt = 0; m_cnt4 = 0;
      m_loading = 0; m_running = 1;
    end else if (m_running) begin
      if (!stall) begin
        m_cnt  = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
        m_cnt4 = (m_cnt4 == 15) ? m_cnt4 : m_cnt4 + 1;
        if (halt) begin
          m_running = 0; m_done = 1;
        end else if (branch && taken) begin
          m_pc = int'(tgt);
        end else begin
          m_pc = (m_pc + 1) % 1024;
        end
      end
    end else if (start) begin
      m_done = 0; m_loading = 1;
    end
    if (lut_we) m_lut[lut_waddr] = lut_wdata;
    @(negedge clk);
  endtask

  task automatic quiet();
    start = 0; stall = 0; branch = 0; taken = 0; halt = 0;
    lut_we = 0; target_idx = '0; lut_waddr = '0; lut_wdata = '0;
  endtask

  task automatic begin_run(input logic [9:0] sa);
    start_addr = sa; start = 1; tick();
    start = 0; tick();
  endtask

  task automatic mid_reset();
    #3 rst_n = 0;
    #1;
    chk("rst_pc", 32'(pc_o), 32'h0);
    chk("rst_cnt", 32'(instr_cnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_fetch", 32'(fetch_en), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    quiet();
    start_addr = '0;
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    tick();
    tick();

    // Reset mid-run
    begin_run(10'h010);
    repeat (5) tick();
    mid_reset();
    tick();

    // Straight-line run across the PC wrap
    begin_run(10'h3FD);
    chk("pc_first", 32'(pc_o), 32'h3FD);
    repeat (4) tick();
    chk("pc_wrapped", 32'(pc_o), 32'h001);
    halt = 1; tick(); halt = 0; tick();

    // Branch taken / not taken / taken without branch
    lut_we = 1; lut_waddr = 5'd7; lut_wdata = 10'h120; tick(); quiet();
    begin_run(10'h040);
    branch = 1; taken = 1; target_idx = 5'd7; tick();
    chk("br_taken", 32'(pc_o), 32'h120);
    taken = 0; tick();
    chk("br_not_taken", 32'(pc_o), 32'h121);
    branch = 0; taken = 1; tick();
    chk("taken_no_br", 32'(pc_o), 32'h122);
    quiet(); halt = 1; tick(); quiet(); tick();

    // Stall priority over halt and branch
    begin_run(10'h080);
    tick();
    stall = 1; halt = 1; branch = 1; taken = 1; target_idx = 5'd7;
    repeat (3) tick();
    chk("stall_pc", 32'(pc_o), 32'h081);
    stall = 0; tick();
    chk("halt_done", 32'(done), 32'h1);
    chk("halt_pc", 32'(pc_o), 32'h081);
    chk("halt_cnt", 32'(instr_cnt), 32'd2);
    quiet(); tick();

    // Same-cycle write/read of the jump table
    lut_we = 1; lut_waddr = 5'd3; lut_wdata = 10'h200; tick(); quiet();
    begin_run(10'h300);
    lut_we = 1; lut_waddr = 5'd3; lut_wdata = 10'h055;
    branch = 1; taken = 1; target_idx = 5'd3; tick();
    chk("lut_old", 32'(pc_o), 32'h200);
    lut_we = 0; tick();
    chk("lut_new", 32'(pc_o), 32'h055);
    quiet(); halt = 1; tick(); quiet(); tick();

    // Halt after 12 instructions, restart, then saturate the small counter
    begin_run(10'h000);
    repeat (11) tick();
    halt = 1; tick(); halt = 0;
    repeat (2) tick();
    chk("done_cnt12", 32'(instr_cnt), 32'd12);
    begin_run(10'h100);
    chk("restart_cnt", 32'(instr_cnt), 32'd0);
    repeat (20) tick();
    chk("sat_small", 32'(cnt_s), 32'd15);
    chk("cnt_big", 32'(instr_cnt), 32'd20);
    halt = 1; tick(); quiet(); tick();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      start      = ($urandom_range(0, 7) == 0);
      start_addr = 10'($urandom);
      stall      = ($urandom_range(0, 4) == 0);
      branch     = 1'($urandom);
      taken      = 1'($urandom);
      target_idx = 5'($urandom);
      halt       = ($urandom_range(0, 24) == 0);
      lut_we     = ($urandom_range(0, 3) == 0);
      lut_waddr  = 5'($urandom);
      lut_wdata  = 10'($urandom);
      if ($urandom_range(0, 199) == 0) mid_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
